n64_joybus_responder: RTL and testbench
=======================================

// Module: n64_joybus_responder
// PURPOSE
//  Controller-side end of the N64 joybus link: decodes the console command byte on the CTRL line and answers like a standard pad.
//  Replies to poll (0x01) with 32 pad bits and to info/reset (0x00/0xFF) with 24 ID bits, followed by a stop bit.
//  Drives the line open-drain through CTRL_OE; the top level ties CTRL = CTRL_OE ? 1'b0 : 1'bz.
//  Used for OSD/menu test injection and for the pad-emulation path.
//  Poll bit order is the one the controller sniffer reports (bit 0 = A sent first), so captured and generated words are interchangeable.
// PARAMETERS
//  T_SHORT    4   low cycles of a '1' data bit and high cycles of a '0' data bit (1us @ CLK_4M)
//  T_LONG     12  low cycles of a '0' data bit and high cycles of a '1' data bit (3us)
//  T_STOP     8   low cycles of the transmitted stop bit (2us)
//  T_THRESH   8   rx decision: low count < T_THRESH -> '1', otherwise '0'
//  T_TURN     8   cycles from the console stop-bit rising edge to the first tx falling edge
//  T_IDLE     32  high cycles that define bus idle and abort a byte in progress
//  T_LOWMAX   32  low cycles that mark a stuck/invalid low
// PORTS
//  CLK_4M      in   1   4 MHz system clock
//  SRST        in   1   synchronous active-high reset
//  CTRL_I      in   1   raw CTRL line level (async; 2-FF synchronized inside)
//  CTRL_OE     out  1   1 = pull CTRL low
//  EN_RESP     in   1   1 = answer commands; 0 = decode only, never drive
//  POLL_DATA   in   32  pad state; bit 0 sent first
//  PAK_BYTE    in   8   third ID byte
//  BUSY        out  1   high from the first command falling edge until back in IDLE
//  CMD_VALID   out  1   one-cycle pulse when a command byte plus its stop bit are complete
//  CMD_CODE    out  8   last command byte, MSB first as received; held until next CMD_VALID
//  RX_ERR      out  1   one-cycle pulse on a malformed command
// BEHAVIOUR
//  Reset values: CTRL_OE=0, BUSY=0, CMD_VALID=0, CMD_CODE=8'h00, RX_ERR=0, state=WAIT_IDLE.
//  Line handling
//   - Edge detection uses the synchronized line only; detection latency is 2 cycles from CTRL_I.
//   - Low and high counters saturate at 63.
//  States
//   WAIT_IDLE: go to IDLE after T_IDLE consecutive high cycles. Any low restarts the count.
//   IDLE: a falling edge -> RX_CMD with bit_cnt=0 and BUSY=1.
//   RX_CMD
//    - On each rising edge, shift in bit = (low_cnt < T_THRESH), MSB first.
//    - After 8 bits -> RX_STOP.
//   RX_STOP
//    - The next low pulse, of any length < T_LOWMAX, is the console stop bit.
//    - On its rising edge, pulse CMD_VALID and update CMD_CODE the same cycle.
//    - Then -> TURN if EN_RESP=1 and the code is 0x00, 0xFF or 0x01; otherwise -> WAIT_IDLE.
//   TURN
//    - At stop-bit rising edge + T_TURN cycles, latch the tx shift word -> TX_BITS.
//    - Poll: POLL_DATA, 32 bits. Info/reset: {8'h05,8'h00,PAK_BYTE}, 24 bits, MSB first.
//   TX_BITS: each bit is 16 cycles. '1' = T_SHORT low then T_LONG high; '0' = T_LONG low then T_SHORT high.
//   TX_STOP: T_STOP cycles low, then release -> WAIT_IDLE.
//  Latched data
//   - POLL_DATA and PAK_BYTE are sampled only at the TURN->TX_BITS cycle.
//   - Later input changes do not affect the reply in flight.
//  Errors (RX_ERR pulse, CTRL_OE stays 0, -> WAIT_IDLE)
//   - Any low >= T_LOWMAX during RX_CMD or RX_STOP.
//   - High >= T_IDLE during RX_CMD or RX_STOP (truncated byte).
//  Input handling while transmitting
//   - CTRL_I is ignored in TURN, TX_BITS and TX_STOP; no contention detection.
//   - EN_RESP falling during TX does not abort the current reply.
//  Other rules
//   - CTRL_OE is registered and never asserted outside TX_BITS and TX_STOP.
//   - SRST mid-transfer: CTRL_OE=0 on the next clock edge; all state returns to reset values.
//   - BUSY drops when WAIT_IDLE->IDLE.
// TESTING
//  Poll: cmd 0x01 + stop, POLL_DATA=32'h0000_0001, EN_RESP=1
//   -> CMD_VALID with CMD_CODE=8'h01.
//   -> After T_TURN: a 4-low/12-high bit, then 31 bits of 12-low/4-high, then 8 cycles low, then release.
//  Info: cmd 0xFF, PAK_BYTE=8'h01 -> 24 bits decode as 05 00 01 MSB first, then stop bit; 0x00 gives the same reply.
//  Unknown/disabled: cmd 0x02 with EN_RESP=1, and cmd 0x01 with EN_RESP=0
//   -> CMD_VALID fires with the code; CTRL_OE stays 0 throughout.
//  Truncated: 5 bits, then line high for 40 cycles -> RX_ERR pulse, no CMD_VALID, IDLE reached after T_IDLE highs.
//  Stuck low: a 40-cycle low inside the command byte -> RX_ERR, no response.
//  Robustness
//   - Toggle POLL_DATA every cycle during TX -> transmitted word equals the value at the latch cycle.
//   - Assert SRST at TX bit 10 -> CTRL_OE=0 next edge, BUSY=0, next poll answered normally.

Source files
------------

// File: rtl/n64_joybus_responder.sv
// Controller-side joybus endpoint: decodes the console command byte on the
// synchronized CTRL line and answers poll/info like a standard pad (open-drain).
module n64_joybus_responder #(
  parameter int unsigned T_SHORT  = 4,
  parameter int unsigned T_LONG   = 12,
  parameter int unsigned T_STOP   = 8,
  parameter int unsigned T_THRESH = 8,
  parameter int unsigned T_TURN   = 8,
  parameter int unsigned T_IDLE   = 32,
  parameter int unsigned T_LOWMAX = 32
) (
  input  logic        clk_4m_i,
  input  logic        srst_i,
  input  logic        ctrl_i,
  output logic        ctrl_oe_o,
  input  logic        en_resp_i,
  input  logic [31:0] poll_data_i,
  input  logic [7:0]  pak_byte_i,
  output logic        busy_o,
  output logic        cmd_valid_o,
  output logic [7:0]  cmd_code_o,
  output logic        rx_err_o
);

  localparam logic [5:0] THRESH    = 6'(T_THRESH);
  localparam logic [5:0] IDLE_CNT  = 6'(T_IDLE);
  localparam logic [5:0] LOWMAX    = 6'(T_LOWMAX);
  localparam logic [5:0] TURN_LOAD = 6'(T_TURN - 2);
  localparam logic [5:0] STOP_LOAD = 6'(T_STOP - 1);
  localparam logic [5:0] BIT_LAST  = 6'(T_SHORT + T_LONG - 1);
  localparam logic [5:0] ONE_TC    = 6'(T_LONG);
  localparam logic [5:0] ZERO_TC   = 6'(T_SHORT);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_RX_CMD,
    S_RX_STOP,
    S_TURN,
    S_TX_BITS,
    S_TX_STOP
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic [5:0]  low_cnt_q, high_cnt_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        is_poll_q, is_poll_d;
  logic [5:0]  tmr_q, tmr_d;
  logic [4:0]  bits_left_q, bits_left_d;
  logic [31:0] tx_sh_q, tx_sh_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic        rx_err_q, rx_err_d;

  logic        line, fall, rise, rx_bad;
  logic [23:0] info_w, info_rev;

  assign line   = sync2_q;
  assign fall   = prev_q & ~sync2_q;
  assign rise   = ~prev_q & sync2_q;
  assign rx_bad = (low_cnt_q >= LOWMAX) || (high_cnt_q >= IDLE_CNT);

  // Info reply goes out MSB first; reversing it lets one LSB-first shifter serve both replies.
  always_comb begin
    info_w   = {8'h05, 8'h00, pak_byte_i};
    info_rev = '0;
    for (int i = 0; i < 24; i++) info_rev[i] = info_w[23-i];
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    is_poll_d   = is_poll_q;
    tmr_d       = tmr_q;
    bits_left_d = bits_left_q;
    tx_sh_d     = tx_sh_q;
    busy_d      = busy_q;
    cmd_valid_d = 1'b0;
    cmd_code_d  = cmd_code_q;
    rx_err_d    = 1'b0;
    oe_d        = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (line && (high_cnt_q >= IDLE_CNT)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        if (fall) begin
          state_d   = S_RX_CMD;
          bit_cnt_d = 3'd0;
          busy_d    = 1'b1;
        end
      end
      S_RX_CMD: begin
        if (rx_bad) begin
          rx_err_d = 1'b1;
          state_d  = S_WAIT_IDLE;
        end else if (rise) begin
          rx_sh_d   = {rx_sh_q[6:0], low_cnt_q < THRESH};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_RX_STOP;
        end
      end
      S_RX_STOP: begin
        if (rx_bad) begin
          rx_err_d = 1'b1;
          state_d  = S_WAIT_IDLE;
        end else if (rise) begin
          cmd_valid_d = 1'b1;
          cmd_code_d  = rx_sh_q;
          if (en_resp_i && (rx_sh_q == 8'h00 || rx_sh_q == 8'hFF || rx_sh_q == 8'h01)) begin
            state_d   = S_TURN;
            tmr_d     = TURN_LOAD;
            is_poll_d = (rx_sh_q == 8'h01);
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_TURN: begin
        if (tmr_q == 6'd0) begin
          state_d = S_TX_BITS;
          tmr_d   = BIT_LAST;
          if (is_poll_q) begin
            tx_sh_d     = poll_data_i;
            bits_left_d = 5'd31;
          end else begin
            tx_sh_d     = {8'h00, info_rev};
            bits_left_d = 5'd23;
          end
        end else begin
          tmr_d = tmr_q - 6'd1;
        end
      end
      S_TX_BITS: begin
        if (tmr_q == 6'd0) begin
          if (bits_left_q == 5'd0) begin
            state_d = S_TX_STOP;
            tmr_d   = STOP_LOAD;
          end else begin
            tx_sh_d     = {1'b0, tx_sh_q[31:1]};
            bits_left_d = bits_left_q - 5'd1;
            tmr_d       = BIT_LAST;
          end
        end else begin
          tmr_d = tmr_q - 6'd1;
        end
      end
      S_TX_STOP: begin
        if (tmr_q == 6'd0) state_d = S_WAIT_IDLE;
        else tmr_d = tmr_q - 6'd1;
      end
      default: state_d = S_WAIT_IDLE;
    endcase
    // Drive computed from next-cycle state so the registered pin matches the bit phase exactly.
    if (state_d == S_TX_BITS) oe_d = tx_sh_d[0] ? (tmr_d >= ONE_TC) : (tmr_d >= ZERO_TC);
    else if (state_d == S_TX_STOP) oe_d = 1'b1;
  end

  always_ff @(posedge clk_4m_i) begin
    if (srst_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      low_cnt_q   <= 6'd0;
      high_cnt_q  <= 6'd0;
      state_q     <= S_WAIT_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 8'h00;
      is_poll_q   <= 1'b0;
      tmr_q       <= 6'd0;
      bits_left_q <= 5'd0;
      tx_sh_q     <= 32'h0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= 8'h00;
      rx_err_q    <= 1'b0;
    end else begin
      sync1_q     <= ctrl_i;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      low_cnt_q   <= line ? 6'd0 : ((low_cnt_q == 6'd63) ? 6'd63 : low_cnt_q + 6'd1);
      high_cnt_q  <= !line ? 6'd0 : ((high_cnt_q == 6'd63) ? 6'd63 : high_cnt_q + 6'd1);
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      is_poll_q   <= is_poll_d;
      tmr_q       <= tmr_d;
      bits_left_q <= bits_left_d;
      tx_sh_q     <= tx_sh_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      rx_err_q    <= rx_err_d;
    end
  end

  assign ctrl_oe_o   = oe_q;
  assign busy_o      = busy_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_code_o  = cmd_code_q;
  assign rx_err_o    = rx_err_q;

endmodule

// File: tb/tb_n64_joybus_responder.sv
// Bench for n64_joybus_responder: console-side driver, open-drain line model
// and a waveform-level reference of the expected pad reply.
module tb_n64_joybus_responder;
  localparam int T_TURN = 8;
  localparam int T_IDLE = 32;

  logic        clk = 1'b0;
  logic        srst, con_drv, en_resp;
  logic [31:0] poll_data;
  logic [7:0]  pak_byte;
  logic        ctrl_oe, busy, cmd_valid, rx_err;
  logic [7:0]  cmd_code;
  logic        ctrl_line;

  always #5 clk = ~clk;

  assign ctrl_line = ctrl_oe ? 1'b0 : con_drv;

  n64_joybus_responder dut (
    .clk_4m_i    (clk),
    .srst_i      (srst),
    .ctrl_i      (ctrl_line),
    .ctrl_oe_o   (ctrl_oe),
    .en_resp_i   (en_resp),
    .poll_data_i (poll_data),
    .pak_byte_i  (pak_byte),
    .busy_o      (busy),
    .cmd_valid_o (cmd_valid),
    .cmd_code_o  (cmd_code),
    .rx_err_o    (rx_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int         n_cv = 0, n_err = 0, n_oe = 0;
  logic [7:0] last_code = 8'h00;

  always @(negedge clk) begin
    if (cmd_valid) begin
      n_cv      <= n_cv + 1;
      last_code <= cmd_code;
    end
    if (rx_err) n_err <= n_err + 1;
    if (ctrl_oe) n_oe <= n_oe + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input int n);
    con_drv = v;
    cyc(n);
  endtask

  task automatic send_bits(input logic [7:0] code, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      drive(1'b0, code[i] ? int'($urandom_range(2, 6)) : int'($urandom_range(9, 20)));
      drive(1'b1, int'($urandom_range(2, 14)));
    end
  endtask

  task automatic send_cmd(input logic [7:0] code);
    send_bits(code, 8);
    drive(1'b0, int'($urandom_range(2, 20)));
    con_drv = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 400) begin
      cyc(1);
      k++;
    end
    check(tag, busy, 0);
    cyc(2);
  endtask

  // Reference: reply bits in transmission order (bit k = k-th bit on the wire).
  function automatic logic [31:0] ref_reply(input logic [7:0] code, input logic [31:0] pd,
                                            input logic [7:0] pk, output int nb);
    logic [23:0] w;
    logic [31:0] seq;
    seq = 32'h0;
    if (code == 8'h01) begin
      seq = pd;
      nb  = 32;
    end else begin
      w  = {8'h05, 8'h00, pk};
      nb = 24;
      for (int k = 0; k < 24; k++) seq[k] = w[23-k];
    end
    return seq;
  endfunction

  task automatic capture(input int nb, input logic [31:0] exp_seq, input bit toggle);
    int          n_s, first_bad, pos, lo, hi;
    logic        s[$];
    logic        e[$];
    logic [31:0] got;
    n_s = nb * 16 + 8 + 16;
    s.push_back(ctrl_oe);
    for (int k = 1; k < n_s; k++) begin
      if (toggle) poll_data = ~poll_data;
      cyc(1);
      s.push_back(ctrl_oe);
    end
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < 16; j++) e.push_back(j < (exp_seq[i] ? 4 : 12));
    for (int j = 0; j < 8; j++) e.push_back(1'b1);
    while (e.size() < n_s) e.push_back(1'b0);
    first_bad = n_s;
    for (int k = 0; k < n_s; k++)
      if (s[k] !== e[k] && first_bad == n_s) first_bad = k;
    check("wave_first_bad_cycle", first_bad, n_s);
    pos = 0;
    got = 32'h0;
    for (int i = 0; i < nb; i++) begin
      lo = 0;
      while (pos < n_s && s[pos] == 1'b1) begin lo++; pos++; end
      hi = 0;
      while (pos < n_s && s[pos] == 1'b0 && hi < 16) begin hi++; pos++; end
      got[i] = (lo > 0 && lo < 8);
    end
    check("reply_bits", got, exp_seq);
    lo = 0;
    while (pos < n_s && s[pos] == 1'b1) begin lo++; pos++; end
    check("stop_len", lo, 8);
  endtask

  task automatic run_txn(input logic [7:0] code, input logic en,
                         input logic [31:0] pd_early, input logic [31:0] pd,
                         input logic [7:0] pk_early, input logic [7:0] pk, input bit toggle);
    int          cv0, er0, oe0, cnt, nb;
    bit          resp;
    logic [31:0] seq;
    en_resp   = en;
    poll_data = pd_early;
    pak_byte  = pk_early;
    cv0 = n_cv;
    er0 = n_err;
    oe0 = n_oe;
    send_cmd(code);
    poll_data = pd;
    pak_byte  = pk;
    check("busy_during_txn", busy, 1);
    resp = en && (code == 8'h00 || code == 8'h01 || code == 8'hFF);
    if (resp) begin
      seq = ref_reply(code, pd, pk, nb);
      cnt = 0;
      while (!ctrl_oe && cnt < 40) begin
        cyc(1);
        cnt++;
      end
      check("turnaround", cnt, T_TURN + 2);
      if (ctrl_oe) capture(nb, seq, toggle);
    end else begin
      cyc(60);
      check("no_drive", n_oe - oe0, 0);
    end
    check("cmd_valid_cnt", n_cv - cv0, 1);
    check("cmd_code_pulse", last_code, code);
    check("rx_err_cnt", n_err - er0, 0);
    wait_idle("busy_idle");
    check("cmd_code_hold", cmd_code, code);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cv0, er0, oe0, cnt;
    logic [7:0]  code;
    logic [31:0] pd;
    srst      = 1'b1;
    con_drv   = 1'b1;
    en_resp   = 1'b0;
    poll_data = 32'h0;
    pak_byte  = 8'h00;
    cyc(4);
    check("rst_oe", ctrl_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_code", cmd_code, 8'h00);
    check("rst_rx_err", rx_err, 0);
    srst = 1'b0;
    cyc(T_IDLE + 8);

    run_txn(8'h01, 1'b1, 32'hDEAD_BEEF, 32'h0000_0001, 8'h00, 8'h00, 1'b0);
    run_txn(8'hFF, 1'b1, 32'h0, 32'h0, 8'hAA, 8'h01, 1'b0);
    run_txn(8'h00, 1'b1, 32'h0, 32'h0, 8'h5A, 8'h01, 1'b0);
    run_txn(8'h02, 1'b1, 32'h1234_5678, 32'h1234_5678, 8'h01, 8'h01, 1'b0);
    run_txn(8'h01, 1'b0, 32'h1234_5678, 32'h1234_5678, 8'h01, 8'h01, 1'b0);

    // Truncated byte: five bits then a long high.
    en_resp = 1'b1;
    cv0 = n_cv; er0 = n_err; oe0 = n_oe;
    send_bits(8'hA5, 5);
    drive(1'b1, 40);
    check("trunc_rx_err", n_err - er0, 1);
    check("trunc_cmd_valid", n_cv - cv0, 0);
    check("trunc_no_drive", n_oe - oe0, 0);
    wait_idle("trunc_idle");

    // Stuck low inside the command byte.
    cv0 = n_cv; er0 = n_err; oe0 = n_oe;
    send_bits(8'h01, 3);
    drive(1'b0, 40);
    drive(1'b1, 4);
    check("stuck_rx_err", n_err - er0, 1);
    check("stuck_cmd_valid", n_cv - cv0, 0);
    wait_idle("stuck_idle");
    check("stuck_no_drive", n_oe - oe0, 0);

    // Input changes after the latch cycle must not reach the wire.
    pd = $urandom;
    run_txn(8'h01, 1'b1, ~pd, pd, 8'h00, 8'h00, 1'b1);

    // Reset in the middle of the reply.
    en_resp   = 1'b1;
    poll_data = $urandom;
    send_cmd(8'h01);
    cnt = 0;
    while (!ctrl_oe && cnt < 40) begin
      cyc(1);
      cnt++;
    end
    check("srst_turnaround", cnt, T_TURN + 2);
    cyc(10 * 16);
    check("pre_srst_oe", ctrl_oe, 1);
    srst = 1'b1;
    cyc(1);
    check("srst_oe", ctrl_oe, 0);
    check("srst_busy", busy, 0);
    check("srst_cmd_code", cmd_code, 8'h00);
    srst = 1'b0;
    cyc(T_IDLE + 8);
    pd = $urandom;
    run_txn(8'h01, 1'b1, pd, pd, 8'h00, 8'h00, 1'b0);

    for (int t = 0; t < 12; t++) begin
      case ($urandom_range(0, 3))
        0: code = 8'h00;
        1: code = 8'h01;
        2: code = 8'hFF;
        default: code = 8'($urandom);
      endcase
      run_txn(code, ($urandom_range(0, 3) != 0), $urandom, $urandom,
              8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
